approx_mul_pipe: RTL
====================

# approx_mul_pipe

Parametrised, pipelined approximate unsigned multiplier. It is the streaming successor to the fixed 8x8 approximate multipliers in the unsigned multiplier library. The upper `W-L` multiplier rows are computed exactly. The lower `L` rows are pair-compressed with a lossy rule, and all columns below `T` are dropped. A per-transaction mode bit selects approximate or exact product, and a valid/ready handshake allows the block to sit in accelerator datapaths with backpressure.

## Interface
- `W`, 8: operand width; must be ≥ 4.
- `L`, 6: number of approximated low multiplier rows; must be even, 0 ≤ L < W.
- `T`, 7: lowest kept column in approximated rows; 0 ≤ T < 2W.
- `CNT_W`, 32: width of the approximate-transaction counter.

- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input transaction valid.
- `in_ready` out 1: block accepts input this cycle.
- `in_x` in W: multiplier.
- `in_y` in W: multiplicand.
- `in_approx` in 1: 1 = approximate product, 0 = exact product.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts result.
- `out_z` out 2W: product.
- `out_approx` out 1: mode bit travelling with the result.
- `approx_cnt` out CNT_W: count of approximate results delivered.

## Operation
- Exact mode: `out_z = x*y`, mod 2^(2W); this never overflows.
- Approximate mode: `out_z = ((x >> L) * y << L) + LOW`, where LOW is computed as follows.
  - For each row pair k = 0..L/2-1 and each column c ≥ T:
    - `a = x[2k] & y[c-2k]` and `b = x[2k+1] & y[c-2k-1]`.
    - An out-of-range y index gives 0.
  - At column c == T, the pair contributes `(a|b) << T`.
  - At column c > T, the pair contributes `(a+b) << c`.
  - Columns < T contribute nothing.
- Approximate mode never exceeds exact mode (absent compensation).
- Accepting a transaction requires `in_valid & in_ready`. A result is delivered on `out_valid & out_ready`.
- `approx_cnt` increments on each delivered result with `out_approx=1`. It saturates at all-ones and never wraps.

## Timing
- 3-stage pipeline with per-stage valid flags v1..v3:
  - S1 registers operands and mode.
  - S2 generates and compresses partial products into sum and carry vectors.
  - S3 registers the final carry-propagate add.
- Latency is 3 cycles from acceptance to `out_valid` when there is no stall. Throughput is 1 per cycle.
- Stage advance rules:
  - `adv3 = out_ready`
  - `adv2 = !v3 | adv3`
  - `adv1 = !v2 | adv2`
  - `in_ready = !v1 | adv1`, combinational from `out_ready`.
- While `out_valid=1` and `out_ready=0`, `out_z` and `out_approx` hold stable. No stage overwrites a valid, non-advancing stage.
- Bubbles collapse: an empty downstream stage is filled even while the output is stalled.
- Reset values: v1..v3=0, `out_valid=0`, `out_z=0`, `out_approx=0`, `approx_cnt=0`. `in_ready=1` in the first cycle after reset.
- Reset mid-operation discards all in-flight transactions. No result for them is ever produced.
- Simultaneous deliver and accept in the same cycle is legal and loses nothing.

## Configuration
- `APPROX_MUL_COMP_EN`: when defined, approximate-mode results add a bias constant `COMP = (L/2) << (T-1)`.
  - For T=0, COMP is 0.
  - The sum saturates to 2^(2W)-1 on overflow.
  - The constant is added even when x=0 or y=0.
- When the macro is undefined, no bias is added and no saturation logic exists.
- Exact mode is unaffected either way.

## Structure
- Package `approx_mul_pkg`:
  - COMP function of (L, T).
  - Partial-product index helper returning 0 when out of range.
  - The parameter legality checks, as elaboration-time assertions.
- One sub-module `approx_pp_compress`, combinational S2 logic: takes x, y and mode, and produces sum and carry vectors of 2W bits.
- The pipeline, handshake and counter live in the top level.

## Test plan
Defaults W=8, L=6, T=7 apply unless stated otherwise.
- x=255, y=255:
  - exact → 65025.
  - approx → 63936, or 64128 with `APPROX_MUL_COMP_EN`.
- x=64, y=1, approx → 64, which is exact because only the upper rows are used. x=0, y=0, approx → 0, or 192 with the macro.
- Streaming and stall:
  - Stream 10 back-to-back transactions with `out_ready=1`: results arrive at cycles 3..12 in order and `in_ready` stays 1.
  - Hold `out_ready=0` for 5 cycles: exactly 3 are buffered, `in_ready=0`, and `out_z` stays stable.
- Assert `rst` with 2 transactions in flight → `out_valid=0` on the next cycle, nothing emerges afterwards, and `approx_cnt=0`.
- CNT_W=2: deliver 5 approximate results and 1 exact result → `approx_cnt` ends at 3 (saturated).
- Random sweep of all 65536 (x, y) pairs in both modes against the formula model: exact mismatches = 0, and the approximate result is ≤ the exact product when the macro is undefined.

Source files
------------

// File: rtl/approx_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : approx_mul_pkg
// Purpose  : Shared constants and helpers for the approximate multiplier:
//            bias constant, bounds-checked partial-product bit select and
//            parameter legality check.
// Revision : 1.0 - initial release
// ============================================================================
package approx_mul_pkg;

    // Widest operand vector the helpers accept (2W product must fit 64 bits)
    localparam int c_pp_max_w = 64;

    // Bit idx of v, or 0 when idx falls outside the w-bit operand
    function automatic logic pp_bit(input logic [c_pp_max_w-1:0] v,
                                    input int                    w,
                                    input int                    idx);
        if (idx < 0 || idx >= w) begin
            return 1'b0;
        end
        return v[idx[5:0]];
    endfunction

    // Bias added to approximate results: (L/2) << (T-1), zero when T is 0
    function automatic logic [63:0] comp_value(input int l, input int t);
        logic [63:0] r_half;
        if (t == 0) begin
            return 64'd0;
        end
        r_half = 64'(l / 2);
        return r_half << (t - 1);
    endfunction

    // Legal parameter combinations for approx_mul_pipe
    function automatic bit params_ok(input int w, input int l, input int t,
                                     input int cnt_w);
        return (w >= 4) && (w <= c_pp_max_w / 2) &&
               (l >= 0) && (l < w) && ((l % 2) == 0) &&
               (t >= 0) && (t < 2 * w) && (cnt_w >= 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/approx_pp_compress.sv
`default_nettype none
// ============================================================================
// Module   : approx_pp_compress
// Purpose  : Combinational partial-product generation and carry-save
//            reduction. Upper rows are exact; in approximate mode the low L
//            rows are pair-compressed (OR at column T, drop columns below T).
// Revision : 1.0 - initial release
// ============================================================================
module approx_pp_compress
    import approx_mul_pkg::*;
#(
    parameter int W = 8,
    parameter int L = 6,
    parameter int T = 7
) (
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    input  logic           approx,
    output logic [2*W-1:0] sum,
    output logic [2*W-1:0] carry
);

    localparam int c_pw = 2 * W;

    logic [c_pp_max_w-1:0] w_y_ext;
    logic [c_pw-1:0]       w_rows [W];
    logic [c_pw-1:0]       w_ops  [W];
    logic [c_pw-1:0]       w_keep_mask;
    logic [c_pw-1:0]       w_s;
    logic [c_pw-1:0]       w_c;
    logic [c_pw-1:0]       w_t;

    assign w_y_ext = c_pp_max_w'(y);

    // Exact partial-product matrix: row i holds x[i] & y shifted to column i
    always_comb begin
        for (int i = 0; i < W; i++) begin
            for (int c = 0; c < c_pw; c++) begin
                w_rows[i][c] = x[i] & pp_bit(w_y_ext, W, c - i);
            end
        end
    end

    // Columns strictly above T survive the lossy pair rule unchanged
    always_comb begin
        for (int c = 0; c < c_pw; c++) begin
            w_keep_mask[c] = (c > T);
        end
    end

    // Operand selection: a row pair keeps a and b above T, ORs them at T
    always_comb begin
        for (int i = 0; i < W; i++) begin
            w_ops[i] = w_rows[i];
        end
        if (approx) begin
            for (int k = 0; k < L / 2; k++) begin
                w_ops[2*k]    = w_rows[2*k] & w_keep_mask;
                w_ops[2*k][T] = w_rows[2*k][T] | w_rows[2*k+1][T];
                w_ops[2*k+1]  = w_rows[2*k+1] & w_keep_mask;
            end
        end
    end

    // Carry-save chain folding every operand row into sum/carry vectors
    always_comb begin
        w_s = '0;
        w_c = '0;
        w_t = '0;
        for (int i = 0; i < W; i++) begin
            w_t = w_s ^ w_c ^ w_ops[i];
            w_c = ((w_s & w_c) | (w_s & w_ops[i]) | (w_c & w_ops[i])) << 1;
            w_s = w_t;
        end
    end

    assign sum   = w_s;
    assign carry = w_c;

endmodule
`default_nettype wire

// File: rtl/approx_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : approx_mul_pipe
// Purpose  : 3-stage pipelined approximate/exact unsigned multiplier with
//            valid/ready handshake and saturating approximate-result counter.
//            Optional macro APPROX_MUL_COMP_EN adds a saturating bias
//            constant to approximate-mode results.
// Revision : 1.0 - initial release
// ============================================================================
module approx_mul_pipe
    import approx_mul_pkg::*;
#(
    parameter int W     = 8,
    parameter int L     = 6,
    parameter int T     = 7,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_x,
    input  logic [W-1:0]     in_y,
    input  logic             in_approx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_z,
    output logic             out_approx,
    output logic [CNT_W-1:0] approx_cnt
);

    if (!params_ok(W, L, T, CNT_W)) begin : g_bad_params
        $error("approx_mul_pipe: illegal parameters W=%0d L=%0d T=%0d CNT_W=%0d",
               W, L, T, CNT_W);
    end

    // Stage registers
    logic             r_v1;
    logic [W-1:0]     r_x1;
    logic [W-1:0]     r_y1;
    logic             r_m1;
    logic             r_v2;
    logic [2*W-1:0]   r_s2;
    logic [2*W-1:0]   r_c2;
    logic             r_m2;
    logic             r_v3;
    logic [2*W-1:0]   r_z3;
    logic             r_m3;
    logic [CNT_W-1:0] r_cnt;

    logic             w_adv1;
    logic             w_adv2;
    logic             w_adv3;
    logic [2*W-1:0]   w_pp_sum;
    logic [2*W-1:0]   w_pp_carry;
    logic [2*W-1:0]   w_cpa;
    logic [2*W-1:0]   w_final;

    // Back-pressure chain: a stage moves when its successor is empty or moving
    assign w_adv3   = out_ready;
    assign w_adv2   = !r_v3 | w_adv3;
    assign w_adv1   = !r_v2 | w_adv2;
    assign in_ready = !r_v1 | w_adv1;

    approx_pp_compress #(
        .W (W),
        .L (L),
        .T (T)
    ) u_compress (
        .x      (r_x1),
        .y      (r_y1),
        .approx (r_m1),
        .sum    (w_pp_sum),
        .carry  (w_pp_carry)
    );

    assign w_cpa = r_s2 + r_c2;

`ifdef APPROX_MUL_COMP_EN
    localparam logic [2*W-1:0] c_comp = (2*W)'(comp_value(L, T));
    logic [2*W:0] w_biased;

    // Bias approximate results, clamping to all-ones on overflow
    always_comb begin
        w_biased = {1'b0, w_cpa} + {1'b0, c_comp};
        w_final  = w_cpa;
        if (r_m2) begin
            w_final = w_biased[2*W] ? '1 : w_biased[2*W-1:0];
        end
    end
`else
    assign w_final = w_cpa;
`endif

    // S1: capture operands and mode on acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_x1 <= '0;
            r_y1 <= '0;
            r_m1 <= 1'b0;
        end else if (in_ready) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_x1 <= in_x;
                r_y1 <= in_y;
                r_m1 <= in_approx;
            end
        end
    end

    // S2: register carry-save sum and carry vectors
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2 <= 1'b0;
            r_s2 <= '0;
            r_c2 <= '0;
            r_m2 <= 1'b0;
        end else if (w_adv1) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_s2 <= w_pp_sum;
                r_c2 <= w_pp_carry;
                r_m2 <= r_m1;
            end
        end
    end

    // S3: register the carry-propagate result; holds while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v3 <= 1'b0;
            r_z3 <= '0;
            r_m3 <= 1'b0;
        end else if (w_adv2) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_z3 <= w_final;
                r_m3 <= r_m2;
            end
        end
    end

    // Saturating count of delivered approximate results
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_v3 && out_ready && r_m3 && !(&r_cnt)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign out_valid  = r_v3;
    assign out_z      = r_z3;
    assign out_approx = r_m3;
    assign approx_cnt = r_cnt;

endmodule
`default_nettype wire
